// File: rtl/clk_route_multi.sv
// Multi-channel emulation clock router: per-channel divided, glitch-free gated clocks with reset sequencers.
// Optional freeze input emu_stall is enabled by defining CLK_ROUTE_STALL_EN.
module clk_route_multi #(
   parameter int N_CH       = 4,
   parameter int DIV_W      = 16,
   parameter int RST_CYCLES = 4
) (
   input  logic                    emu_clk,
   input  logic                    emu_rst_n,
`ifdef CLK_ROUTE_STALL_EN
   input  logic                    emu_stall,
`endif
   input  logic [N_CH-1:0]         ch_run,
   input  logic [N_CH*DIV_W-1:0]   ch_half_period,
   output logic [N_CH-1:0]         ch_clk_val,
   output logic [N_CH-1:0]         ch_rise,
   output logic [N_CH-1:0]         ch_active,
   output logic [N_CH-1:0]         ch_rst
);

   localparam int SEQ_W = (RST_CYCLES == 0) ? 1 : $clog2(RST_CYCLES + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} ch_state_t;

   logic stall;
`ifdef CLK_ROUTE_STALL_EN
   assign stall = emu_stall;
`else
   assign stall = 1'b0;
`endif

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      ch_state_t        state_reg, state_next;
      logic [DIV_W-1:0] cnt_reg, cnt_next;
      logic             clk_reg, clk_next;
      logic             rise_reg, rise_next;
      logic [SEQ_W-1:0] seq_reg, seq_next;
      logic             rst_reg, rst_next;
      logic [DIV_W-1:0] half;
      logic             expire;

      assign half   = ch_half_period[gi*DIV_W +: DIV_W];
      assign expire = (cnt_reg == '0);

      always_comb begin
         state_next = state_reg;
         cnt_next   = cnt_reg;
         clk_next   = clk_reg;
         rise_next  = 1'b0;
         case (state_reg)
            S_IDLE: begin
               cnt_next = '0;
               clk_next = 1'b0;
               if (ch_run[gi]) begin
                  state_next = S_RUN;
                  cnt_next   = half;
               end
            end
            S_RUN, S_STOPPING: begin
               if (!ch_run[gi] && !clk_reg) begin
                  state_next = S_IDLE;
                  cnt_next   = '0;
               end else if (!expire) begin
                  cnt_next   = cnt_reg - 1'b1;
                  state_next = ch_run[gi] ? S_RUN : S_STOPPING;
               end else if (!ch_run[gi]) begin
                  // High phase has run its full length: finish low and park.
                  clk_next   = 1'b0;
                  state_next = S_IDLE;
                  cnt_next   = '0;
               end else begin
                  clk_next   = !clk_reg;
                  rise_next  = !clk_reg;
                  cnt_next   = half;
                  state_next = S_RUN;
               end
            end
            default: state_next = S_IDLE;
         endcase
         if (stall) begin
            state_next = state_reg;
            cnt_next   = cnt_reg;
            clk_next   = clk_reg;
            rise_next  = 1'b0;
         end
      end

      // ch_rst lags the count by one edge so it drops the edge after the final rise.
      always_comb begin
         seq_next = seq_reg;
         if (rise_next && (seq_reg < SEQ_W'(RST_CYCLES)))
            seq_next = seq_reg + 1'b1;
         rst_next = stall ? rst_reg : (seq_reg < SEQ_W'(RST_CYCLES));
      end

      always_ff @(posedge emu_clk) begin
         if (!emu_rst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            clk_reg   <= 1'b0;
            rise_reg  <= 1'b0;
            seq_reg   <= '0;
            rst_reg   <= 1'b1;
         end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            clk_reg   <= clk_next;
            rise_reg  <= rise_next;
            seq_reg   <= seq_next;
            rst_reg   <= rst_next;
         end
      end

      assign ch_clk_val[gi] = clk_reg;
      assign ch_rise[gi]    = rise_reg;
      assign ch_active[gi]  = (state_reg != S_IDLE);
      assign ch_rst[gi]     = rst_reg;
   end

endmodule

// File: tb/tb_clk_route_multi.sv
// Directed bench for clk_route_multi: time-based reference model checked every cycle plus literal edge checks.
module tb_clk_route_multi;
   localparam int N_CH       = 4;
   localparam int DIV_W      = 16;
   localparam int RST_CYCLES = 4;

   logic                  emu_clk;
   logic                  emu_rst_n;
   logic                  emu_stall;
   logic [N_CH-1:0]       ch_run;
   logic [N_CH*DIV_W-1:0] ch_half_period;
   logic [N_CH-1:0]       ch_clk_val;
   logic [N_CH-1:0]       ch_rise;
   logic [N_CH-1:0]       ch_active;
   logic [N_CH-1:0]       ch_rst;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   bit chk_en = 0;

   // Model: a running channel toggles at an absolute edge number, rescheduled H+1 edges later.
   bit m_act  [N_CH];
   bit m_lvl  [N_CH];
   bit m_rise [N_CH];
   bit m_rst  [N_CH];
   int m_cnt  [N_CH];
   int m_next [N_CH];

   clk_route_multi #(
      .N_CH(N_CH), .DIV_W(DIV_W), .RST_CYCLES(RST_CYCLES)
   ) dut (
      .emu_clk(emu_clk),
      .emu_rst_n(emu_rst_n),
`ifdef CLK_ROUTE_STALL_EN
      .emu_stall(emu_stall),
`endif
      .ch_run(ch_run),
      .ch_half_period(ch_half_period),
      .ch_clk_val(ch_clk_val),
      .ch_rise(ch_rise),
      .ch_active(ch_active),
      .ch_rst(ch_rst)
   );

   initial emu_clk = 1'b0;
   always #5 emu_clk = ~emu_clk;

   task automatic model_step();
      cyc++;
      for (int i = 0; i < N_CH; i++) begin
         int h;
         h = int'(ch_half_period[i*DIV_W +: DIV_W]);
         m_rise[i] = 1'b0;
         if (!emu_rst_n) begin
            m_act[i] = 1'b0; m_lvl[i] = 1'b0; m_rst[i] = 1'b1; m_cnt[i] = 0;
         end else if (emu_stall) begin
            if (m_act[i]) m_next[i]++;
         end else begin
            m_rst[i] = (m_cnt[i] < RST_CYCLES);
            if (!m_act[i]) begin
               if (ch_run[i]) begin
                  m_act[i]  = 1'b1;
                  m_next[i] = cyc + h + 1;
               end
            end else if (!ch_run[i] && !m_lvl[i]) begin
               m_act[i] = 1'b0;
            end else if (cyc == m_next[i]) begin
               if (!ch_run[i]) begin
                  m_lvl[i] = 1'b0;
                  m_act[i] = 1'b0;
               end else begin
                  m_lvl[i]  = !m_lvl[i];
                  m_rise[i] = m_lvl[i];
                  if (m_lvl[i] && m_cnt[i] < RST_CYCLES) m_cnt[i]++;
                  m_next[i] = cyc + h + 1;
               end
            end
         end
      end
      chk_en = 1'b1;
   endtask

   task automatic cmp1(string name, int ch, logic act, bit exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL cmp %s ch%0d edge %0d: got %b expected %b", name, ch, cyc, act, exp);
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < N_CH; i++) begin
         cmp1("clk_val", i, ch_clk_val[i], m_lvl[i]);
         cmp1("rise",    i, ch_rise[i],    m_rise[i]);
         cmp1("active",  i, ch_active[i],  m_act[i]);
         cmp1("rst",     i, ch_rst[i],     m_rst[i]);
      end
   endtask

   initial forever begin
      @(posedge emu_clk);
      model_step();
   end

   initial forever begin
      @(negedge emu_clk);
      if (chk_en) compare_all();
   end

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s edge %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic goto(int e);
      while (cyc < e) begin
         @(posedge emu_clk);
         #1;
      end
   endtask

   initial begin
      int base, a, b, c;
      emu_rst_n = 1'b0;
      emu_stall = 1'b0;
      ch_run    = '1;
      ch_half_period = {16'd3, 16'd0, 16'd5, 16'd2};
      goto(3);
      chk("reset clk_val", 32'(ch_clk_val), 32'h0);
      chk("reset active",  32'(ch_active),  32'h0);
      chk("reset rst",     32'(ch_rst),     32'hF);
      chk("reset rise",    32'(ch_rise),    32'h0);
      ch_run    = '0;
      emu_rst_n = 1'b1;
      $display("[TB] reset checked at edge %0d", cyc);

      // ch0 H=2 sampled at base+10
      base = cyc;
      goto(base + 9);  ch_run[0] = 1'b1;
      goto(base + 12); chk("div clk_val@12", 32'(ch_clk_val[0]), 32'h0);
                       chk("div active@12",  32'(ch_active[0]),  32'h1);
      goto(base + 13); chk("div rise@13",    32'(ch_rise[0]),    32'h1);
                       chk("div clk_val@13", 32'(ch_clk_val[0]), 32'h1);
      goto(base + 14); chk("div rise@14",    32'(ch_rise[0]),    32'h0);
      goto(base + 16); chk("div clk_val@16", 32'(ch_clk_val[0]), 32'h0);
      goto(base + 19); chk("div rise@19",    32'(ch_rise[0]),    32'h1);
      goto(base + 31); chk("seq rst@31",     32'(ch_rst[0]),     32'h1);
      goto(base + 32); chk("seq rst@32",     32'(ch_rst[0]),     32'h0);
      goto(base + 33); ch_run[0] = 1'b0;
      goto(base + 36); chk("stop active",    32'(ch_active[0]),  32'h0);
      goto(base + 40); ch_run[0] = 1'b1;
      goto(base + 42); chk("restart rst",    32'(ch_rst[0]),     32'h0);
      goto(base + 44); chk("restart rise",   32'(ch_rise[0]),    32'h1);
      $display("[TB] divider/sequencer done at edge %0d", cyc);

      // ch1 H=5 glitch-free stop
      a = base + 50;
      goto(a - 1);  ch_run[1] = 1'b1;
      goto(a + 6);  chk("stop rise@6", 32'(ch_rise[1]), 32'h1);
                    ch_run[1] = 1'b0;
      goto(a + 11); chk("stop hi@11",  32'(ch_clk_val[1]), 32'h1);
      goto(a + 12); chk("stop lo@12",  32'(ch_clk_val[1]), 32'h0);
                    chk("stop idle@12", 32'(ch_active[1]), 32'h0);
      b = a + 15;
      goto(b - 1);  ch_run[1] = 1'b1;
      goto(b + 6);  ch_run[1] = 1'b0;
      goto(b + 9);  ch_run[1] = 1'b1;
      goto(b + 12); chk("resume lo@12",     32'(ch_clk_val[1]), 32'h0);
                    chk("resume active@12", 32'(ch_active[1]),  32'h1);
      goto(b + 18); chk("resume rise@18",   32'(ch_rise[1]),    32'h1);
      $display("[TB] glitch-free stop done at edge %0d", cyc);

`ifdef CLK_ROUTE_STALL_EN
      goto(b + 19); emu_stall = 1'b1;
      goto(b + 26); emu_stall = 1'b0;
      goto(b + 30); chk("stall hi@30", 32'(ch_clk_val[1]), 32'h1);
      goto(b + 31); chk("stall lo@31", 32'(ch_clk_val[1]), 32'h0);
      $display("[TB] stall done at edge %0d", cyc);
`endif

      // ch2 H=0 and ch3 H=3 together, ch3 retuned to H=1 mid high phase
      c = b + 40;
      goto(c - 1);  ch_run[3:2] = 2'b11;
      goto(c + 1);  chk("h0 rise@1",   32'(ch_rise[2]),    32'h1);
      goto(c + 2);  chk("h0 lo@2",     32'(ch_clk_val[2]), 32'h0);
      goto(c + 4);  chk("h3 rise@4",   32'(ch_rise[3]),    32'h1);
      goto(c + 5);  ch_half_period[3*DIV_W +: DIV_W] = 16'd1;
      goto(c + 7);  chk("h0 rst@7",    32'(ch_rst[2]),     32'h1);
                    chk("h3 hi@7",     32'(ch_clk_val[3]), 32'h1);
      goto(c + 8);  chk("h0 rst@8",    32'(ch_rst[2]),     32'h0);
                    chk("h3 lo@8",     32'(ch_clk_val[3]), 32'h0);
      goto(c + 9);  chk("h1 lo@9",     32'(ch_clk_val[3]), 32'h0);
      goto(c + 10); chk("h1 rise@10",  32'(ch_rise[3]),    32'h1);
      goto(c + 12); chk("h1 lo@12",    32'(ch_clk_val[3]), 32'h0);
      $display("[TB] independence done at edge %0d", cyc);

      goto(c + 30);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/clk_route_multi.md
# clk_route_multi

Multi-channel emulator clock router: the next generation of the single-channel emulation clock/reset route. Derives N_CH independent gated emulation clocks from the one emulator clock. Each channel has a programmable divider, glitch-free start/stop and its own reset sequencer. Sits between the emulator clock/reset source and the per-domain emulated model logic, which consumes `ch_clk_val`, `ch_rise` and `ch_rst`.

## Interface
- `N_CH`, 4, number of clock channels (1..32)
- `DIV_W`, 16, width of each half-period field
- `RST_CYCLES`, 4, channel rising edges for which `ch_rst` is held after reset release (0..255)

- `emu_clk`  in  1  emulator clock; sole clock
- `emu_rst_n`  in  1  synchronous, active-low reset
- `ch_run`  in  N_CH  per-channel run request, level
- `ch_half_period`  in  N_CH*DIV_W  channel i at bits [i*DIV_W +: DIV_W]; value H gives half-period H+1 emu_clk cycles
- `ch_clk_val`  out  N_CH  gated clock level per channel, registered
- `ch_rise`  out  N_CH  one-cycle pulse, high in the cycle `ch_clk_val` becomes 1
- `ch_active`  out  N_CH  channel in RUN or STOPPING
- `ch_rst`  out  N_CH  active-high reset for the channel domain

## Operation
- Per-channel FSM: IDLE, RUN, STOPPING. The state is encoded on `ch_active`: 0 in IDLE, 1 otherwise.
- IDLE: `ch_clk_val`=0, counter=0. If `ch_run`=1, go to RUN, counter<=H, `ch_clk_val` stays 0.
- RUN, counter≠0: decrement.
- RUN, counter==0: toggle `ch_clk_val`, reload counter<=H (H sampled only at reload/entry). A 0→1 toggle asserts `ch_rise` in the same cycle.
- RUN with `ch_run`=0:
  - if `ch_clk_val`=0: go to IDLE next edge, no toggle.
  - if `ch_clk_val`=1: go to STOPPING.
- STOPPING: keep counting. At counter==0, drive `ch_clk_val` to 0 and go to IDLE. If `ch_run` returns to 1, go to RUN with no counter disturbance and no extra edge.
- No glitches: `ch_clk_val` never changes other than by a counter expiry or by reset.
- Reset sequencer: per-channel saturating counter of `ch_rise` pulses, width ceil(log2(RST_CYCLES+1)).
  - `ch_rst` = (count < RST_CYCLES).
  - The count is not cleared by stop/start; only `emu_rst_n` clears it.
- Channels are fully independent; there is no cross-channel arbitration.

## Timing
- Reset (`emu_rst_n`=0 at an edge): all FSMs go to IDLE; counters=0; `ch_clk_val`=0; `ch_rise`=0; `ch_active`=0; `ch_rst`=all 1. If RST_CYCLES=0, `ch_rst`=0 on the first edge after release.
- Reset asserted mid-operation: all of the above within one edge, regardless of state. `ch_clk_val` may drop from 1 to 0 in this case; this is the only permitted non-expiry change.
- `ch_run` sampled at edge t in IDLE: `ch_active`=1 after t. First rise at edge t+H+1. Period is 2(H+1); duty cycle 50%.
- H=0: toggle every cycle, giving emu_clk/2.
- `ch_rise` and the RST_CYCLES-th rise coincide; `ch_rst` deasserts on the following edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- A change in `ch_half_period` takes effect at the next reload only.

## Configuration
- `CLK_ROUTE_STALL_EN` defined:
  - adds input port `emu_stall` (1 bit, after `emu_rst_n`).
  - While `emu_stall`=1, all counters, FSM states, `ch_clk_val` and reset sequencers hold, and `ch_rise`=0.
  - Reset overrides stall.
  - On release, operation resumes with counters exactly as they were when frozen.
- Not defined: the port is absent and behaviour is identical to `emu_stall`=0.

## Test plan
- Reset: hold `emu_rst_n`=0 for 3 cycles with all `ch_run`=1 -> `ch_clk_val`=0, `ch_active`=0, `ch_rst`=all 1, `ch_rise`=0.
- Divider: ch0 H=2, `ch_run` rises at edge 10 -> `ch_clk_val` rises at edge 13, falls at 16, rises at 19; `ch_rise` high only at 13 and 19.
- Reset sequencer: RST_CYCLES=4, H=0 -> `ch_rst` deasserts on the edge after the 4th `ch_rise`. It stays 0 across a stop/start cycle.
- Glitch-free stop: H=5, drop `ch_run` 1 cycle after a rise -> high phase lasts the full 6 cycles, then IDLE. Reassert `ch_run` during STOPPING -> no extra edge, and the period continues at 12.
- Independence/H=0: ch0 H=0, ch1 H=3 run together -> ch0 period 2, ch1 period 8. Changing ch1 H to 1 mid-phase alters only the phases after the next reload.
- Stall (macro on): assert `emu_stall` for 7 cycles mid high phase -> all levels frozen, no `ch_rise`, and the remaining phase length is unchanged after release.
